// File: rtl/fw_pkg.sv
// Shared types for the filter-wheel move sequencer: FSM state encoding and coil phase table.
// Coil drive bits are {A+, A-, B+, B-}.
package fw_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLedWarm,
      StSample,
      StStep,
      StDone,
      StFault
   } fwState_e;

   localparam logic [3:0] CoilOff    = 4'b0000;
   localparam logic [3:0] CoilPhase0 = 4'b1010;
   localparam logic [3:0] CoilPhase1 = 4'b0110;
   localparam logic [3:0] CoilPhase2 = 4'b0101;
   localparam logic [3:0] CoilPhase3 = 4'b1001;

   // Full-step pattern for a phase index; each pattern energises one end of each winding.
   function automatic logic [3:0] phaseCoil(input logic [1:0] idx);
      logic [3:0] c;
      case (idx)
         2'd0:    c = CoilPhase0;
         2'd1:    c = CoilPhase1;
         2'd2:    c = CoilPhase2;
         default: c = CoilPhase3;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fw_step_timer.sv
// Loadable down-counter for the move sequencer; flags the sensor-sample cycle and the
// last cycle of a step (or of the LED warm-up when loaded with a shorter value).
module fw_step_timer #(
   parameter int unsigned STEP_DIV  = 5000,
   parameter int unsigned SENSE_DLY = 500,
   parameter int unsigned CntW      = $clog2(STEP_DIV)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [CntW-1:0] loadVal,
   output logic            sampleStb,
   output logic            endStb
);

   // A step load of STEP_DIV-1 reaches this value SENSE_DLY cycles after entry.
   localparam logic [CntW-1:0] SampleVal = CntW'(STEP_DIV - 1 - SENSE_DLY);

   logic [CntW-1:0] cntQ;

   always_ff @(posedge clk) begin
      if (rst) begin
         cntQ <= '0;
      end else if (load) begin
         cntQ <= loadVal;
      end else if (cntQ != '0) begin
         cntQ <= cntQ - CntW'(1);
      end
   end

   assign sampleStb = (cntQ == SampleVal);
   assign endStb    = (cntQ == '0);

endmodule

// File: rtl/fw_move_sequencer.sv
// Filter-wheel move sequencer: warms the position LED, samples the slot/home sensors and
// steps the motor forward one full step at a time until the target is seen or the budget runs out.
module fw_move_sequencer
   import fw_pkg::*;
#(
   parameter int unsigned STEP_DIV  = 5000,
   parameter int unsigned SENSE_DLY = 500,
   parameter int unsigned MAX_STEPS = 2400,
   parameter int unsigned HOLD      = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_home,
   input  logic [2:0] cmd_target,
   input  logic       pos_home,
   input  logic [2:0] pos_bits,
   output logic       led_en,
   output logic [3:0] coil,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [2:0] cur_pos
);

   localparam int unsigned TmrW  = $clog2(STEP_DIV);
   localparam int unsigned StepW = $clog2(MAX_STEPS + 1);

   localparam logic [TmrW-1:0]  WarmLoad = TmrW'(SENSE_DLY - 1);
   localparam logic [TmrW-1:0]  StepLoad = TmrW'(STEP_DIV - 1);
   localparam logic [StepW-1:0] StepMax  = StepW'(MAX_STEPS);

   fwState_e         stateQ, stateD;
   logic [1:0]       phaseQ, phaseD;
   logic [3:0]       coilQ, coilD;
   logic [StepW-1:0] stepCntQ, stepCntD;
   logic [2:0]       targetQ, targetD;
   logic             homeQ, homeD;
   logic [2:0]       curPosQ, curPosD;

   logic            timerLoad;
   logic [TmrW-1:0] timerVal;
   logic            sampleStb;
   logic            endStb;
   logic            match;
   logic            enterStep;

   fw_step_timer #(
      .STEP_DIV  (STEP_DIV),
      .SENSE_DLY (SENSE_DLY),
      .CntW      (TmrW)
   ) uTimer (
      .clk       (clk),
      .rst       (rst),
      .load      (timerLoad),
      .loadVal   (timerVal),
      .sampleStb (sampleStb),
      .endStb    (endStb)
   );

   // Home moves look only at the home flag; slot moves only at the slot code.
   assign match = homeQ ? pos_home : (pos_bits == targetQ);

   always_comb begin
      stateD    = stateQ;
      phaseD    = phaseQ;
      coilD     = coilQ;
      stepCntD  = stepCntQ;
      targetD   = targetQ;
      homeD     = homeQ;
      curPosD   = curPosQ;
      timerLoad = 1'b0;
      timerVal  = StepLoad;
      enterStep = 1'b0;

      unique case (stateQ)
         StIdle: begin
            if (cmd_valid) begin
               stateD    = StLedWarm;
               targetD   = cmd_target;
               homeD     = cmd_home;
               stepCntD  = '0;
               timerLoad = 1'b1;
               timerVal  = WarmLoad;
            end
         end
         StLedWarm: begin
            if (endStb) begin
               stateD = StSample;
            end
         end
         StSample: begin
            curPosD = pos_bits;
            if (match) begin
               stateD = StDone;
            end else begin
               stateD    = StStep;
               enterStep = 1'b1;
            end
         end
         StStep: begin
            if (sampleStb) begin
               curPosD = pos_bits;
            end
            // Sample wins over step end so a late sample still gets its match check.
            if (sampleStb && match) begin
               stateD = StDone;
            end else if (endStb) begin
               if (stepCntQ == StepMax) begin
                  stateD = StFault;
               end else begin
                  enterStep = 1'b1;
               end
            end
         end
         StDone: begin
            stateD = StIdle;
         end
         StFault: begin
            stateD = StFault;
         end
         default: begin
            stateD = StIdle;
         end
      endcase

      // phaseQ always names the pattern the next step will drive.
      if (enterStep) begin
         timerLoad = 1'b1;
         timerVal  = StepLoad;
         coilD     = phaseCoil(phaseQ);
         phaseD    = phaseQ + 2'd1;
         stepCntD  = stepCntQ + StepW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= StIdle;
         phaseQ   <= 2'd0;
         coilQ    <= CoilOff;
         stepCntQ <= '0;
         targetQ  <= 3'd0;
         homeQ    <= 1'b0;
         curPosQ  <= 3'd0;
      end else begin
         stateQ   <= stateD;
         phaseQ   <= phaseD;
         coilQ    <= coilD;
         stepCntQ <= stepCntD;
         targetQ  <= targetD;
         homeQ    <= homeD;
         curPosQ  <= curPosD;
      end
   end

   always_comb begin
      coil = CoilOff;
      unique case (stateQ)
         StStep:  coil = coilQ;
         StFault: coil = CoilOff;
         default: coil = (HOLD != 0) ? coilQ : CoilOff;
      endcase
   end

   assign cmd_ready = (stateQ == StIdle);
   assign busy      = (stateQ != StIdle) && (stateQ != StFault);
   assign done      = (stateQ == StDone);
   assign fault     = (stateQ == StFault);
   assign led_en    = (stateQ == StLedWarm) || (stateQ == StSample) || (stateQ == StStep);
   assign cur_pos   = curPosQ;

endmodule
